// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from imem and holds one instruction for decode (valid/ready).
// Optional macro FETCH_MISALIGN_TRAP_EN adds instr_misaligned and traps unaligned redirect targets.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 128,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_fault,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        instr_misaligned,
`endif
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_pc, w_pc_next;
   logic [31:0] r_instr, w_instr_next;
   logic [31:0] r_instr_pc, w_instr_pc_next;
   logic        r_fault, w_fault_next;
   logic        w_oob;
   logic        w_capture;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        r_mis, w_mis_next;
   logic [31:0] r_mis_pc, w_mis_pc_next;
   logic        r_mis_out, w_mis_out_next;
`endif

   always_comb begin
      // NOTE: every next-state variable gets its hold value first so no path infers a latch.
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_instr_next    = r_instr;
      w_instr_pc_next = r_instr_pc;
      w_fault_next    = r_fault;
`ifdef FETCH_MISALIGN_TRAP_EN
      w_mis_next      = r_mis;
      w_mis_pc_next   = r_mis_pc;
      w_mis_out_next  = r_mis_out;
`endif
      w_oob     = (r_pc >= IMEM_LIMIT);
      // A handshake in the redirect cycle still completes; only the refill is skipped.
      w_capture = !redirect_valid && ((r_state == S_FETCH) || instr_ready);

      if (redirect_valid) begin
         w_state_next = S_FETCH;
         w_pc_next    = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
         w_mis_next    = (redirect_pc[1:0] != 2'b00);
         w_mis_pc_next = redirect_pc;
`endif
      end else if (w_capture) begin
         w_state_next    = S_HOLD;
         w_pc_next       = r_pc + 32'd4;
         w_instr_pc_next = r_pc;
         w_instr_next    = w_oob ? NOP_INSTR : imem_rd;
         w_fault_next    = w_oob;
`ifdef FETCH_MISALIGN_TRAP_EN
         w_mis_out_next  = r_mis;
         w_mis_next      = 1'b0;
         if (r_mis) begin
            w_instr_next    = NOP_INSTR;
            w_fault_next    = 1'b1;
            w_instr_pc_next = r_mis_pc;
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_instr    <= NOP_INSTR;
         r_instr_pc <= 32'h0000_0000;
         r_fault    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_mis      <= 1'b0;
         r_mis_pc   <= 32'h0000_0000;
         r_mis_out  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_instr    <= w_instr_next;
         r_instr_pc <= w_instr_pc_next;
         r_fault    <= w_fault_next;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_mis      <= w_mis_next;
         r_mis_pc   <= w_mis_pc_next;
         r_mis_out  <= w_mis_out_next;
`endif
      end
   end

   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == S_HOLD);
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_fault = r_fault;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign instr_misaligned = r_mis_out;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan checks plus randomized traffic against a behavioural fetch model.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        instr_misaligned;
`endif

   fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(128), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_fault    (instr_fault),
`ifdef FETCH_MISALIGN_TRAP_EN
      .instr_misaligned(instr_misaligned),
`endif
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:127];
   assign imem_rd = mem[imem_addr[8:2]];

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Word the spec says a fetch from byte address a must deliver.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      return (a < 32'd512) ? mem[idx[6:0]] : NOP;
   endfunction

   // Behavioural model: one held slot, refilled whenever it is empty or being consumed.
   logic [31:0] m_pc, m_instr, m_ipc;
   logic        m_valid, m_fault;
   logic        m_mis, m_mis_out;
   logic [31:0] m_mis_pc;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_pc <= 32'h0; m_valid <= 1'b0; m_instr <= NOP; m_ipc <= 32'h0; m_fault <= 1'b0;
         m_mis <= 1'b0; m_mis_pc <= 32'h0; m_mis_out <= 1'b0;
      end else if (redirect_valid) begin
         m_pc     <= {redirect_pc[31:2], 2'b00};
         m_valid  <= 1'b0;
         m_mis    <= (redirect_pc % 4) != 0;
         m_mis_pc <= redirect_pc;
      end else if (!m_valid || instr_ready) begin
         m_valid <= 1'b1;
         m_pc    <= m_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
         m_mis     <= 1'b0;
         m_mis_out <= m_mis;
         if (m_mis) begin
            m_instr <= NOP; m_fault <= 1'b1; m_ipc <= m_mis_pc;
         end else begin
            m_instr <= word_at(m_pc); m_fault <= (m_pc >= 32'd512); m_ipc <= m_pc;
         end
`else
         m_instr <= word_at(m_pc); m_fault <= (m_pc >= 32'd512); m_ipc <= m_pc;
`endif
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_imem_addr", imem_addr, m_pc);
         check("model_valid", 32'(instr_valid), 32'(m_valid));
         if (m_valid) begin
            check("model_instr", instr, m_instr);
            check("model_instr_pc", instr_pc, m_ipc);
            check("model_fault", 32'(instr_fault), 32'(m_fault));
`ifdef FETCH_MISALIGN_TRAP_EN
            check("model_misaligned", 32'(instr_misaligned), 32'(m_mis_out));
`endif
         end
      end
   end

   task automatic expect_instr(input string name, input logic [31:0] w, input logic [31:0] pc,
                               input logic f);
      check({name, "_valid"}, 32'(instr_valid), 32'd1);
      check({name, "_instr"}, instr, w);
      check({name, "_pc"}, instr_pc, pc);
      check({name, "_fault"}, 32'(instr_fault), 32'(f));
   endtask

   initial begin
      logic [31:0] prog [0:20];
      prog = '{32'h00500113, 32'h00c00193, 32'hff718393, 32'h0023e233, 32'h0041f2b3,
               32'h004282b3, 32'h02728863, 32'h0041a233, 32'h00020463, 32'h00000293,
               32'h0023a233, 32'h005203b3, 32'h402383b3, 32'h0471aa23, 32'h06002103,
               32'h005104b3, 32'h008001ef, 32'h00100113, 32'h00910133, 32'h0221a023,
               32'h00210063};
      for (int i = 0; i < 128; i++) mem[i] = (i < 21) ? prog[i] : $urandom;

      reset_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr", instr, NOP);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_fault", 32'(instr_fault), 32'd0);
      reset_n = 1'b1;

      @(negedge clk); expect_instr("t1_c1", 32'h00500113, 32'h0, 1'b0);
      @(negedge clk); expect_instr("t1_c2", 32'h00c00193, 32'h4, 1'b0);
      @(negedge clk); expect_instr("t1_c3", 32'hff718393, 32'h8, 1'b0);
      @(negedge clk); expect_instr("t2_hold0", 32'h0023e233, 32'hc, 1'b0);
      instr_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         expect_instr("t2_hold", 32'h0023e233, 32'hc, 1'b0);
         check("t2_addr", imem_addr, 32'h10);
      end
      instr_ready = 1'b1;
      @(negedge clk); expect_instr("t2_release", 32'h0041f2b3, 32'h10, 1'b0);

      instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h44;
      @(negedge clk); check("t3_bubble", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b0; instr_ready = 1'b1;
      @(negedge clk); expect_instr("t3_target", 32'h00100113, 32'h44, 1'b0);

      instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk); expect_instr("t4_held", 32'h00020463, 32'h20, 1'b0);
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h50;
      @(negedge clk); check("t4_bubble", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b0;
      @(negedge clk); expect_instr("t4_target", 32'h00210063, 32'h50, 1'b0);

      redirect_valid = 1'b1; redirect_pc = 32'h1fc;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk); expect_instr("t5_last", mem[127], 32'h1fc, 1'b0);
      @(negedge clk); expect_instr("t5_oob", NOP, 32'h200, 1'b1);

      instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h44; reset_n = 1'b0;
      @(negedge clk);
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_addr", imem_addr, 32'h0);
      reset_n = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1;
      @(negedge clk); expect_instr("t6_restart", 32'h00500113, 32'h0, 1'b0);

`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_valid = 1'b1; redirect_pc = 32'h46;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk);
      expect_instr("t6_mis", NOP, 32'h46, 1'b1);
      check("t6_mis_flag", 32'(instr_misaligned), 32'd1);
      @(negedge clk);
      expect_instr("t6_mis_next", 32'h00910133, 32'h48, 1'b0);
      check("t6_mis_clear", 32'(instr_misaligned), 32'd0);
`else
      redirect_valid = 1'b1; redirect_pc = 32'h46;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk); expect_instr("t6_align", 32'h00100113, 32'h44, 1'b0);
`endif

      for (int c = 0; c < 3000; c++) begin
         reset_n        = ($urandom_range(0, 149) != 0);
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = $urandom_range(0, 600);
            1:       redirect_pc = 32'hffff_fff0 + $urandom_range(0, 15);
            2:       redirect_pc = $urandom;
            default: redirect_pc = $urandom_range(480, 520);
         endcase
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
